// File: rtl/sobol_uniform_gen_pkg.sv
// ============================================================================
//  sobol_uniform_gen_pkg : shared types, Q-format defaults and reset direction table
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sobol_uniform_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int QINT_DEF  = 16;
  localparam int QFRAC_DEF = 16;
  localparam int MBITS_DEF = 32;
  localparam int NDIM_DEF  = 4;
  localparam int NW_DEF    = 32;

  // Van der Corput direction number for bit k: a single one at MBITS-1-k.
  function automatic logic [63:0] vdc_dir(input int k, input int mbits);
    return 64'(1) << (mbits - 1 - k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sobol_uniform_gen_if.sv
// ============================================================================
//  sobol_uniform_gen_if : valid/ready sample stream carrying uniform u values
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface sobol_uniform_gen_if #(
  parameter int WIDTH = 32
) ();
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] u_out;

  modport master (output valid_out, output u_out, input ready_in);
  modport slave  (input valid_out, input u_out, output ready_in);
endinterface

`default_nettype wire

// File: rtl/sobol_uniform_gen_lzb.sv
// ============================================================================
//  sobol_lzb : lowest-zero-bit priority encoder, saturating at MBITS-1
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sobol_lzb #(
  parameter int NW    = 32,
  parameter int MBITS = 32
) (
  input  logic [NW-1:0]                                 n,
  output logic [((MBITS > 1) ? $clog2(MBITS) : 1)-1:0] c
);
  localparam int CW = (MBITS > 1) ? $clog2(MBITS) : 1;

  logic found;

  always_comb begin
    c     = CW'(MBITS - 1);
    found = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (!found && !n[i]) begin
        found = 1'b1;
        if (i < MBITS - 1) c = CW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sobol_uniform_gen.sv
// ============================================================================
//  sobol_uniform_gen : Gray-code Sobol generator streaming Q(QINT).(QFRAC) u in (0,1)
//  Optional digital shift guarded by macro SOBOL_SHIFT_EN.     Revision : 1.0
// ============================================================================
`default_nettype none

module sobol_uniform_gen
  import sobol_uniform_gen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int QINT  = QINT_DEF,
  parameter int QFRAC = QFRAC_DEF,
  parameter int MBITS = MBITS_DEF,
  parameter int NDIM  = NDIM_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [NW-1:0]                                npoints,
  output logic                                         busy,
  output logic                                         done,
  input  logic                                         dir_we,
  input  logic [((NDIM > 1) ? $clog2(NDIM) : 1)-1:0]   dir_dim,
  input  logic [((MBITS > 1) ? $clog2(MBITS) : 1)-1:0] dir_bit,
  input  logic [MBITS-1:0]                             dir_data,
`ifdef SOBOL_SHIFT_EN
  input  logic                                         shift_we,
  input  logic [((NDIM > 1) ? $clog2(NDIM) : 1)-1:0]   shift_dim,
  input  logic [MBITS-1:0]                             shift_data,
`endif
  sobol_uniform_gen_if.master                          s_if
);
  localparam int DW = (NDIM > 1) ? $clog2(NDIM) : 1;
  localparam int CW = (MBITS > 1) ? $clog2(MBITS) : 1;
  localparam logic [DW-1:0] LAST_DIM = DW'(NDIM - 1);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic             done_q, done_d;
  logic [MBITS-1:0] x_q [NDIM];
  logic [MBITS-1:0] x_d [NDIM];
  logic [MBITS-1:0] v_q [NDIM][MBITS];
  logic [MBITS-1:0] v_d [NDIM][MBITS];
  logic [NW-1:0]    n_q, n_d;
  logic [DW-1:0]    d_ptr_q, d_ptr_d;
  logic [NW-1:0]    remaining_q, remaining_d;
  logic [NW-1:0]    npoints_q, npoints_d;
`ifdef SOBOL_SHIFT_EN
  logic [MBITS-1:0] s_q [NDIM];
  logic [MBITS-1:0] s_d [NDIM];
`endif

  logic [CW-1:0]    c_idx;
  logic [MBITS-1:0] x_sel;
  logic [QFRAC-1:0] frac;
  logic [WIDTH-1:0] u_map;

  sobol_lzb #(.NW(NW), .MBITS(MBITS)) u_lzb (.n(n_q), .c(c_idx));

  // Output mapping: top QFRAC bits of the (optionally shifted) point, zero never emitted.
  always_comb begin
`ifdef SOBOL_SHIFT_EN
    x_sel = x_q[d_ptr_q] ^ s_q[d_ptr_q];
`else
    x_sel = x_q[d_ptr_q];
`endif
    frac  = x_sel[MBITS-1 -: QFRAC];
    u_map = WIDTH'({{QINT{1'b0}}, frac});
    if (frac == '0) u_map = WIDTH'(1);
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    u_d         = u_q;
    done_d      = 1'b0;
    x_d         = x_q;
    v_d         = v_q;
    n_d         = n_q;
    d_ptr_d     = d_ptr_q;
    remaining_d = remaining_q;
    npoints_d   = npoints_q;
`ifdef SOBOL_SHIFT_EN
    s_d         = s_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (dir_we && (int'(dir_dim) < NDIM)) v_d[dir_dim][dir_bit] = dir_data;
`ifdef SOBOL_SHIFT_EN
        if (shift_we && (int'(shift_dim) < NDIM)) s_d[shift_dim] = shift_data;
`endif
        if (start) begin
          if (npoints == '0) begin
            done_d = 1'b1;
          end else begin
            npoints_d = npoints;
            state_d   = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        for (int d = 0; d < NDIM; d++) x_d[d] = v_q[d][0];
        n_d         = NW'(1);
        d_ptr_d     = '0;
        remaining_d = npoints_q;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // remaining_q reaching zero marks that the final sample is already in u_q.
        if ((remaining_q != '0) && (!valid_q || s_if.ready_in)) begin
          valid_d          = 1'b1;
          u_d              = u_map;
          x_d[d_ptr_q]     = x_q[d_ptr_q] ^ v_q[d_ptr_q][c_idx];
          if (d_ptr_q == LAST_DIM) begin
            d_ptr_d     = '0;
            n_d         = n_q + NW'(1);
            remaining_d = remaining_q - NW'(1);
          end else begin
            d_ptr_d = d_ptr_q + DW'(1);
          end
        end else if ((remaining_q == '0) && valid_q && s_if.ready_in) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      u_q         <= '0;
      done_q      <= 1'b0;
      n_q         <= '0;
      d_ptr_q     <= '0;
      remaining_q <= '0;
      npoints_q   <= '0;
      for (int d = 0; d < NDIM; d++) begin
        x_q[d] <= '0;
`ifdef SOBOL_SHIFT_EN
        s_q[d] <= '0;
`endif
        for (int k = 0; k < MBITS; k++) v_q[d][k] <= MBITS'(vdc_dir(k, MBITS));
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      u_q         <= u_d;
      done_q      <= done_d;
      x_q         <= x_d;
      v_q         <= v_d;
      n_q         <= n_d;
      d_ptr_q     <= d_ptr_d;
      remaining_q <= remaining_d;
      npoints_q   <= npoints_d;
`ifdef SOBOL_SHIFT_EN
      s_q         <= s_d;
`endif
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign s_if.valid_out = valid_q;
  assign s_if.u_out     = u_q;

endmodule

`default_nettype wire

// File: tb/tb_sobol_uniform_gen.sv
// ============================================================================
//  tb_sobol_uniform_gen : directed, table-driven bench for sobol_uniform_gen
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sobol_uniform_gen;

  typedef struct {
    logic [31:0] np;
    bit          stall;
    bit          inject;
    logic [31:0] e [4];
    int          ne;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: NDIM=1
  logic        a_start = 1'b0, a_dir_we = 1'b0;
  logic [31:0] a_np = '0, a_dir_data = '0;
  logic [0:0]  a_dir_dim = '0;
  logic [4:0]  a_dir_bit = '0;
  logic        a_busy, a_done;
  // instance B: NDIM=2
  logic        b_start = 1'b0, b_dir_we = 1'b0;
  logic [31:0] b_np = '0, b_dir_data = '0;
  logic [0:0]  b_dir_dim = '0;
  logic [4:0]  b_dir_bit = '0;
  logic        b_busy, b_done;
`ifdef SOBOL_SHIFT_EN
  logic        a_shift_we = 1'b0, b_shift_we = 1'b0;
  logic [0:0]  a_shift_dim = '0, b_shift_dim = '0;
  logic [31:0] a_shift_data = '0, b_shift_data = '0;
`endif

  sobol_uniform_gen_if #(.WIDTH(32)) a_if ();
  sobol_uniform_gen_if #(.WIDTH(32)) b_if ();

  sobol_uniform_gen #(.WIDTH(32), .QINT(16), .QFRAC(16), .MBITS(32), .NDIM(1), .NW(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .npoints(a_np), .busy(a_busy), .done(a_done),
    .dir_we(a_dir_we), .dir_dim(a_dir_dim), .dir_bit(a_dir_bit), .dir_data(a_dir_data),
`ifdef SOBOL_SHIFT_EN
    .shift_we(a_shift_we), .shift_dim(a_shift_dim), .shift_data(a_shift_data),
`endif
    .s_if(a_if)
  );

  sobol_uniform_gen #(.WIDTH(32), .QINT(16), .QFRAC(16), .MBITS(32), .NDIM(2), .NW(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .npoints(b_np), .busy(b_busy), .done(b_done),
    .dir_we(b_dir_we), .dir_dim(b_dir_dim), .dir_bit(b_dir_bit), .dir_data(b_dir_data),
`ifdef SOBOL_SHIFT_EN
    .shift_we(b_shift_we), .shift_dim(b_shift_dim), .shift_data(b_shift_data),
`endif
    .s_if(b_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_a(input vec_t t);
    int          got, cyc, first_cyc;
    bit          held_v, injected;
    logic [31:0] held_u;
    got = 0; cyc = 0; first_cyc = -1; held_v = 0; injected = 0; held_u = '0;
    @(negedge clk);
    a_start = 1'b1;
    a_np    = t.np;
    @(negedge clk);
    while (got < t.ne && cyc < 300) begin
      a_start  = 1'b0;
      a_dir_we = 1'b0;
      if (held_v) begin
        chk("stall_valid", 32'(a_if.valid_out), 32'd1);
        chk("stall_hold", a_if.u_out, held_u);
      end
      if (a_if.valid_out && first_cyc < 0) begin
        first_cyc = cyc;
        chk("first_latency", 32'(cyc), 32'd2);
      end
      // Ignored mid-run write would otherwise change sample 4.
      if (t.inject && a_if.valid_out && !injected) begin
        injected   = 1;
        a_start    = 1'b1;
        a_dir_we   = 1'b1;
        a_dir_dim  = '0;
        a_dir_bit  = 5'd2;
        a_dir_data = '0;
      end
      a_if.ready_in = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held_v = 0;
      if (a_if.valid_out) begin
        if (a_if.ready_in) begin
          chk("sample_a", a_if.u_out, t.e[got]);
          got++;
        end else begin
          held_v = 1;
          held_u = a_if.u_out;
        end
      end
      @(negedge clk);
      cyc++;
    end
    a_if.ready_in = 1'b0;
    a_start       = 1'b0;
    a_dir_we      = 1'b0;
    chk("run_a_complete", 32'(got), 32'(t.ne));
    chk("done_pulse", 32'(a_done), 32'd1);
    chk("valid_drop", 32'(a_if.valid_out), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(a_done), 32'd0);
    chk("busy_idle", 32'(a_busy), 32'd0);
  endtask

  vec_t tbl [5];
  vec_t sh;

  initial begin
    int          got, cyc;
    logic [31:0] b_exp [4];
    a_if.ready_in = 1'b0;
    b_if.ready_in = 1'b0;

    tbl[0] = '{np: 32'd4, stall: 1'b0, inject: 1'b0, e: '{32'h8000, 32'hC000, 32'h4000, 32'h6000}, ne: 4};
    tbl[1] = '{np: 32'd4, stall: 1'b1, inject: 1'b0, e: '{32'h8000, 32'hC000, 32'h4000, 32'h6000}, ne: 4};
    tbl[2] = '{np: 32'd4, stall: 1'b0, inject: 1'b1, e: '{32'h8000, 32'hC000, 32'h4000, 32'h6000}, ne: 4};
    tbl[3] = '{np: 32'd2, stall: 1'b1, inject: 1'b0, e: '{32'h8000, 32'hC000, 32'h0, 32'h0}, ne: 2};
    tbl[4] = '{np: 32'd3, stall: 1'b0, inject: 1'b0, e: '{32'h8000, 32'hC000, 32'h4000, 32'h0}, ne: 3};
    sh     = '{np: 32'd1, stall: 1'b0, inject: 1'b0, e: '{32'h0001, 32'h0, 32'h0, 32'h0}, ne: 1};

    repeat (3) @(negedge clk);
    chk("rst_valid_a", 32'(a_if.valid_out), 32'd0);
    chk("rst_u_a", a_if.u_out, 32'd0);
    chk("rst_busy_a", 32'(a_busy), 32'd0);
    chk("rst_done_a", 32'(a_done), 32'd0);
    chk("rst_valid_b", 32'(b_if.valid_out), 32'd0);
    chk("rst_busy_b", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_a(tbl[i]);

    // npoints == 0: done next cycle, no samples
    @(negedge clk);
    a_start = 1'b1;
    a_np    = 32'd0;
    @(negedge clk);
    a_start = 1'b0;
    chk("zero_done", 32'(a_done), 32'd1);
    chk("zero_busy", 32'(a_busy), 32'd0);
    chk("zero_valid", 32'(a_if.valid_out), 32'd0);
    @(negedge clk);
    chk("zero_done_clear", 32'(a_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_no_valid", 32'(a_if.valid_out), 32'd0);
    end

    // NDIM=2, dim1 table written; second write shares its cycle with start
    b_exp = '{32'h8000, 32'h8000, 32'hC000, 32'h4000};
    @(negedge clk);
    b_dir_we = 1'b1; b_dir_dim = 1'b1; b_dir_bit = 5'd0; b_dir_data = 32'h8000_0000;
    @(negedge clk);
    b_dir_bit = 5'd1; b_dir_data = 32'hC000_0000;
    b_start = 1'b1; b_np = 32'd2;
    @(negedge clk);
    b_dir_we = 1'b0; b_start = 1'b0;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 100) begin
      b_if.ready_in = 1'b1;
      if (b_if.valid_out) begin
        chk("sample_b", b_if.u_out, b_exp[got]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    b_if.ready_in = 1'b0;
    chk("run_b_complete", 32'(got), 32'd4);
    chk("done_b", 32'(b_done), 32'd1);
    chk("valid_drop_b", 32'(b_if.valid_out), 32'd0);

    // Corrupt the table, then reset mid-run: the table must come back too
    @(negedge clk);
    a_dir_we = 1'b1; a_dir_dim = '0; a_dir_bit = 5'd1; a_dir_data = '0;
    @(negedge clk);
    a_dir_we = 1'b0;
    a_start  = 1'b1; a_np = 32'd8;
    @(negedge clk);
    a_start = 1'b0;
    a_if.ready_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrun_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_if.valid_out), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_u", a_if.u_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_if.ready_in = 1'b0;
    run_a(tbl[0]);

`ifdef SOBOL_SHIFT_EN
    @(negedge clk);
    a_shift_we = 1'b1; a_shift_dim = '0; a_shift_data = 32'h8000_0000;
    @(negedge clk);
    a_shift_we = 1'b0;
    run_a(sh);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
